// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped single-word-line instruction cache; optional ICACHE_STATS_EN adds hit/miss counters
module icache #(
   parameter int INDEX_WIDTH = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        clear,
   input  logic        if_enable,
   input  logic [31:0] if_addr,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic        mc_enable,
   output logic [31:0] mc_addr,
   input  logic        mc_valid,
   input  logic [31:0] mc_instr
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int LINES = 1 << INDEX_WIDTH;
   localparam int TAG_W = 30 - INDEX_WIDTH;

   typedef enum logic {IDLE, MISS} state_t;

   state_t                 state_q, state_d;
   logic                   drop_q, drop_d;
   logic                   if_valid_d;
   logic [31:0]            if_instr_d;
   logic                   mc_enable_d;
   logic [31:0]            mc_addr_d;

   logic [LINES-1:0]       valid_q;
   logic [TAG_W-1:0]       tag_mem  [LINES];
   logic [31:0]            data_mem [LINES];

   logic [INDEX_WIDTH-1:0] req_idx, miss_idx;
   logic [TAG_W-1:0]       req_tag, miss_tag;
   logic                   lookup_hit, accept_hit, start_miss, fill;
   logic                   unused_addr_bits;

   // The held miss address doubles as the fill address, so no separate latch is needed.
   assign req_idx  = if_addr[INDEX_WIDTH+1:2];
   assign req_tag  = if_addr[31:INDEX_WIDTH+2];
   assign miss_idx = mc_addr[INDEX_WIDTH+1:2];
   assign miss_tag = mc_addr[31:INDEX_WIDTH+2];
   assign unused_addr_bits = ^if_addr[1:0];

   assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
   assign accept_hit = (state_q == IDLE) && !clear && if_enable && lookup_hit;
   assign start_miss = (state_q == IDLE) && !clear && if_enable && !lookup_hit;
   assign fill       = (state_q == MISS) && mc_valid;

   // State and output registers; everything freezes while rdy is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         drop_q    <= 1'b0;
         if_valid  <= 1'b0;
         if_instr  <= 32'h0;
         mc_enable <= 1'b0;
         mc_addr   <= 32'h0;
      end else if (rdy) begin
         state_q   <= state_d;
         drop_q    <= drop_d;
         if_valid  <= if_valid_d;
         if_instr  <= if_instr_d;
         mc_enable <= mc_enable_d;
         mc_addr   <= mc_addr_d;
      end
   end

   // Next-state: leave IDLE on a miss, return once the controller answers.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_miss) state_d = MISS;
         MISS:    if (mc_valid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output next values: hit answer, request launch, and fill answer unless flushed.
   always_comb begin
      if_valid_d  = 1'b0;
      if_instr_d  = if_instr;
      mc_enable_d = mc_enable;
      mc_addr_d   = mc_addr;
      drop_d      = drop_q;
      case (state_q)
         IDLE: begin
            if (accept_hit) begin
               if_instr_d = data_mem[req_idx];
               if_valid_d = 1'b1;
            end else if (start_miss) begin
               mc_enable_d = 1'b1;
               mc_addr_d   = {if_addr[31:2], 2'b00};
               drop_d      = 1'b0;
            end
         end
         MISS: begin
            if (clear) drop_d = 1'b1;
            if (mc_valid) begin
               mc_enable_d = 1'b0;
               if (!drop_q && !clear) begin
                  if_instr_d = mc_instr;
                  if_valid_d = 1'b1;
               end
            end
         end
         default: begin
            mc_enable_d = 1'b0;
         end
      endcase
   end

   // Valid bits: cleared by reset, set by every completed fill (even a flushed one).
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (rdy && fill) begin
         valid_q[miss_idx] <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset; the valid bit guards them.
   always_ff @(posedge clk) begin
      if (!rst && rdy && fill) begin
         tag_mem[miss_idx]  <= miss_tag;
         data_mem[miss_idx] <= mc_instr;
      end
   end

`ifdef ICACHE_STATS_EN
   // Access statistics: accepted hits and entries into MISS.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count  <= 32'h0;
         miss_count <= 32'h0;
      end else if (rdy) begin
         if (accept_hit) hit_count  <= hit_count + 32'd1;
         if (start_miss) miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule
